apb_gpio_dbnc: RTL and testbench

Next-generation APB GPIO peripheral. It adds four things to the base GPIO:
- per-pin programmable debounce filtering on inputs;
- atomic set/clear/toggle aliases of the output register;
- an any-edge trigger mode;
- address-decode error reporting.

It sits on the APB peripheral bus. It drives pad buffers (gpio_o/gpio_oe) and raises a single level interrupt to the interrupt controller.

---
 rtl/apb_gpio_dbnc.sv | 258 +++++++++++++++++++++++++
 tb/tb_apb_gpio_dbnc.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_gpio_dbnc.sv
// APB GPIO peripheral with per-pin debounce, atomic set/clear/toggle aliases, level/edge triggers.
// Optional LOCK register at address 15 is built when GPIO_LOCK_EN is defined.
module apb_gpio_dbnc #(
  parameter int PADDR_SIZE   = 32,
  parameter int PDATA_SIZE   = 32,
  parameter int INPUT_STAGES = 2,
  parameter int DBNC_CNT_W   = 8
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic [PADDR_SIZE-1:0]   PADDR,
  input  logic                    PWRITE,
  input  logic [PDATA_SIZE/8-1:0] PSTRB,
  input  logic [PDATA_SIZE-1:0]   PWDATA,
  output logic [PDATA_SIZE-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic                    irq_o,
  input  logic [PDATA_SIZE-1:0]   gpio_i,
  output logic [PDATA_SIZE-1:0]   gpio_o,
  output logic [PDATA_SIZE-1:0]   gpio_oe
);

  localparam int ADDR_MODE     = 0;
  localparam int ADDR_DIR      = 1;
  localparam int ADDR_OUT      = 2;
  localparam int ADDR_IN       = 3;
  localparam int ADDR_TRTYPE   = 4;
  localparam int ADDR_TRLVL0   = 5;
  localparam int ADDR_TRLVL1   = 6;
  localparam int ADDR_TRSTAT   = 7;
  localparam int ADDR_IRQENA   = 8;
  localparam int ADDR_OUTSET   = 9;
  localparam int ADDR_OUTCLR   = 10;
  localparam int ADDR_OUTTGL   = 11;
  localparam int ADDR_DBNCENA  = 12;
  localparam int ADDR_DBNCLIM  = 13;
  localparam int ADDR_RAW      = 14;
`ifdef GPIO_LOCK_EN
  localparam int ADDR_LOCK     = 15;
  localparam int LAST_ADDR     = 15;
`else
  localparam int LAST_ADDR     = 14;
`endif

  function automatic logic [PDATA_SIZE-1:0] mergeBytes(
    input logic [PDATA_SIZE-1:0] oldVal,
    input logic [PDATA_SIZE-1:0] mask,
    input logic [PDATA_SIZE-1:0] newVal
  );
    return (oldVal & ~mask) | (newVal & mask);
  endfunction

  logic [LAST_ADDR:0]                   regHit;
  logic                                 mapped;
  logic                                 wrEn;
  logic [PDATA_SIZE-1:0]                byteMask;
  logic [PDATA_SIZE-1:0]                wrData;
  logic [PDATA_SIZE-1:0]                lockMask;
  logic [PDATA_SIZE-1:0]                rdData;

  logic [PDATA_SIZE-1:0]                mode_q, mode_d;
  logic [PDATA_SIZE-1:0]                dir_q, dir_d;
  logic [PDATA_SIZE-1:0]                out_q, out_d;
  logic [PDATA_SIZE-1:0]                trType_q, trType_d;
  logic [PDATA_SIZE-1:0]                trLvl0_q, trLvl0_d;
  logic [PDATA_SIZE-1:0]                trLvl1_q, trLvl1_d;
  logic [PDATA_SIZE-1:0]                trStat_q, trStat_d;
  logic [PDATA_SIZE-1:0]                trStatClr;
  logic [PDATA_SIZE-1:0]                irqEna_q, irqEna_d;
  logic [PDATA_SIZE-1:0]                dbncEna_q, dbncEna_d;
  logic [DBNC_CNT_W-1:0]                dbncLimit_q, dbncLimit_d;

  logic [INPUT_STAGES-1:0][PDATA_SIZE-1:0] sync_q;
  logic [PDATA_SIZE-1:0]                sync;
  logic [PDATA_SIZE-1:0]                flt_q, flt_d;
  logic [PDATA_SIZE-1:0]                fltDly_q;
  logic [PDATA_SIZE-1:0][DBNC_CNT_W-1:0] cnt_q, cnt_d;

  logic [PDATA_SIZE-1:0]                rise, fall, trEvent;
  logic                                 irq_q;
  logic [PDATA_SIZE-1:0]                gpioO_q, gpioOe_q;

  // Address decode compares the full PADDR so aliases above the map stay unmapped.
  always_comb begin
    for (int r = 0; r <= LAST_ADDR; r++) begin
      regHit[r] = (PADDR == PADDR_SIZE'(r));
    end
  end

  always_comb begin
    for (int b = 0; b < PDATA_SIZE/8; b++) begin
      byteMask[b*8 +: 8] = {8{PSTRB[b]}};
    end
  end

  assign mapped = |regHit;
  assign wrEn   = PSEL & PENABLE & PWRITE;
  assign wrData = PWDATA & byteMask;

`ifdef GPIO_LOCK_EN
  logic [PDATA_SIZE-1:0] lock_q, lock_d;

  assign lock_d   = (wrEn && regHit[ADDR_LOCK]) ? (lock_q | wrData) : lock_q;
  assign lockMask = lock_q;

  always_ff @(posedge PCLK) begin
    if (PRESET) lock_q <= '0;
    else        lock_q <= lock_d;
  end
`else
  assign lockMask = '0;
`endif

  always_comb begin
    mode_d      = mode_q;
    dir_d       = dir_q;
    out_d       = out_q;
    trType_d    = trType_q;
    trLvl0_d    = trLvl0_q;
    trLvl1_d    = trLvl1_q;
    irqEna_d    = irqEna_q;
    dbncEna_d   = dbncEna_q;
    dbncLimit_d = dbncLimit_q;
    trStatClr   = '0;
    if (wrEn) begin
      if (regHit[ADDR_MODE])    mode_d    = mergeBytes(mode_q, byteMask & ~lockMask, PWDATA);
      if (regHit[ADDR_DIR])     dir_d     = mergeBytes(dir_q, byteMask & ~lockMask, PWDATA);
      if (regHit[ADDR_OUT] || regHit[ADDR_IN])
                                out_d     = mergeBytes(out_q, byteMask, PWDATA);
      if (regHit[ADDR_OUTSET])  out_d     = out_q | wrData;
      if (regHit[ADDR_OUTCLR])  out_d     = out_q & ~wrData;
      if (regHit[ADDR_OUTTGL])  out_d     = out_q ^ wrData;
      if (regHit[ADDR_TRTYPE])  trType_d  = mergeBytes(trType_q, byteMask, PWDATA);
      if (regHit[ADDR_TRLVL0])  trLvl0_d  = mergeBytes(trLvl0_q, byteMask, PWDATA);
      if (regHit[ADDR_TRLVL1])  trLvl1_d  = mergeBytes(trLvl1_q, byteMask, PWDATA);
      if (regHit[ADDR_TRSTAT])  trStatClr = wrData;
      if (regHit[ADDR_IRQENA])  irqEna_d  = mergeBytes(irqEna_q, byteMask, PWDATA);
      if (regHit[ADDR_DBNCENA]) dbncEna_d = mergeBytes(dbncEna_q, byteMask, PWDATA);
      if (regHit[ADDR_DBNCLIM])
        dbncLimit_d = (dbncLimit_q & ~byteMask[DBNC_CNT_W-1:0]) | wrData[DBNC_CNT_W-1:0];
    end
    // A new event on the same cycle as a W1C clear keeps the bit set.
    trStat_d = (trStat_q & ~trStatClr) | trEvent;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      mode_q      <= '0;
      dir_q       <= '0;
      out_q       <= '0;
      trType_q    <= '0;
      trLvl0_q    <= '0;
      trLvl1_q    <= '0;
      trStat_q    <= '0;
      irqEna_q    <= '0;
      dbncEna_q   <= '0;
      dbncLimit_q <= '0;
    end else begin
      mode_q      <= mode_d;
      dir_q       <= dir_d;
      out_q       <= out_d;
      trType_q    <= trType_d;
      trLvl0_q    <= trLvl0_d;
      trLvl1_q    <= trLvl1_d;
      trStat_q    <= trStat_d;
      irqEna_q    <= irqEna_d;
      dbncEna_q   <= dbncEna_d;
      dbncLimit_q <= dbncLimit_d;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= gpio_i;
      for (int s = 1; s < INPUT_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync = sync_q[INPUT_STAGES-1];

  // A counter above a freshly lowered limit is treated as already at the limit.
  always_comb begin
    for (int n = 0; n < PDATA_SIZE; n++) begin
      flt_d[n] = flt_q[n];
      cnt_d[n] = '0;
      if (!dbncEna_q[n]) begin
        flt_d[n] = sync[n];
      end else if (sync[n] != flt_q[n]) begin
        if (cnt_q[n] >= dbncLimit_q) flt_d[n] = sync[n];
        else                         cnt_d[n] = cnt_q[n] + DBNC_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      flt_q    <= '0;
      fltDly_q <= '0;
      cnt_q    <= '0;
    end else begin
      flt_q    <= flt_d;
      fltDly_q <= flt_q;
      cnt_q    <= cnt_d;
    end
  end

  assign rise    = flt_q & ~fltDly_q;
  assign fall    = ~flt_q & fltDly_q;
  assign trEvent = ( trType_q & ((trLvl0_q & fall)   | (trLvl1_q & rise)))
                 | (~trType_q & ((trLvl0_q & ~flt_q) | (trLvl1_q & flt_q)));

  // Open-drain pins never drive high; they release the pad instead.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      irq_q    <= 1'b0;
      gpioO_q  <= '0;
      gpioOe_q <= '0;
    end else begin
      irq_q    <= |(irqEna_q & trStat_q);
      gpioO_q  <= ~mode_q & out_q;
      gpioOe_q <= dir_q & ~(mode_q & out_q);
    end
  end

  always_comb begin
    rdData = '0;
    if (regHit[ADDR_MODE])    rdData = mode_q;
    if (regHit[ADDR_DIR])     rdData = dir_q;
    if (regHit[ADDR_OUT])     rdData = out_q;
    if (regHit[ADDR_IN])      rdData = flt_q;
    if (regHit[ADDR_TRTYPE])  rdData = trType_q;
    if (regHit[ADDR_TRLVL0])  rdData = trLvl0_q;
    if (regHit[ADDR_TRLVL1])  rdData = trLvl1_q;
    if (regHit[ADDR_TRSTAT])  rdData = trStat_q;
    if (regHit[ADDR_IRQENA])  rdData = irqEna_q;
    if (regHit[ADDR_DBNCENA]) rdData = dbncEna_q;
    if (regHit[ADDR_DBNCLIM]) rdData = PDATA_SIZE'(dbncLimit_q);
    if (regHit[ADDR_RAW])     rdData = sync;
`ifdef GPIO_LOCK_EN
    if (regHit[ADDR_LOCK])    rdData = lock_q;
`endif
  end

  assign PRDATA  = (PSEL && !PWRITE && !PRESET) ? rdData : '0;
  assign PSLVERR = PSEL & PENABLE & ~mapped & ~PRESET;
  assign PREADY  = 1'b1;
  assign irq_o   = irq_q;
  assign gpio_o  = gpioO_q;
  assign gpio_oe = gpioOe_q;

endmodule

// File: tb/tb_apb_gpio_dbnc.sv
// Self-checking bench for apb_gpio_dbnc: expected values are queued as stimulus is driven
// and popped as the DUT outputs are sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_apb_gpio_dbnc;

  localparam int PADDR_SIZE   = 32;
  localparam int PDATA_SIZE   = 32;
  localparam int INPUT_STAGES = 2;
  localparam int DBNC_CNT_W   = 8;
  localparam int DBNC_LIMIT   = 3;
`ifdef GPIO_LOCK_EN
  localparam int LAST_ADDR    = 15;
`else
  localparam int LAST_ADDR    = 14;
`endif

  logic                    PCLK = 1'b0;
  logic                    PRESET;
  logic                    PSEL, PENABLE, PWRITE;
  logic [PADDR_SIZE-1:0]   PADDR;
  logic [PDATA_SIZE/8-1:0] PSTRB;
  logic [PDATA_SIZE-1:0]   PWDATA, PRDATA;
  logic                    PREADY, PSLVERR, irq_o;
  logic [PDATA_SIZE-1:0]   gpio_i, gpio_o, gpio_oe;

  apb_gpio_dbnc #(
    .PADDR_SIZE(PADDR_SIZE), .PDATA_SIZE(PDATA_SIZE),
    .INPUT_STAGES(INPUT_STAGES), .DBNC_CNT_W(DBNC_CNT_W)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR),
    .PWRITE(PWRITE), .PSTRB(PSTRB), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .irq_o(irq_o), .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } expEntry_t;

  expEntry_t expQ[$];
  int checkCount = 0;
  int passCount  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
  endtask

  task automatic expectValue(input string tag, input logic [31:0] value);
    expEntry_t e;
    e.tag   = tag;
    e.value = value;
    expQ.push_back(e);
  endtask

  task automatic compareNext(input logic [31:0] actual);
    expEntry_t e;
    if (expQ.size() == 0) begin
      checkOutput("sb_underflow", 32'(expQ.size()), 32'd1);
    end else begin
      e = expQ.pop_front();
      checkOutput(e.tag, actual, e.value);
    end
  endtask

  task automatic applyStimulus(input logic [PDATA_SIZE-1:0] pins);
    @(negedge PCLK);
    gpio_i = pins;
  endtask

  task automatic busIdle();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apbWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data; PSTRB = strb;
    @(negedge PCLK);
    PENABLE = 1'b1;
    expectValue($sformatf("pslverr_wr_a%0d", addr), {31'b0, addr > LAST_ADDR});
    #1 compareNext({31'b0, PSLVERR});
    @(posedge PCLK);
    @(negedge PCLK);
    busIdle();
  endtask

  task automatic apbRead(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
    expectValue(tag, exp);
    #1 compareNext(PRDATA);
    @(negedge PCLK);
    PENABLE = 1'b1;
    expectValue($sformatf("pslverr_rd_a%0d", addr), {31'b0, addr > LAST_ADDR});
    #1 compareNext({31'b0, PSLVERR});
    @(negedge PCLK);
    busIdle();
  endtask

  // Combinational peek without waiting for a clock; used inside cycle-exact sequences.
  task automatic peekReg(input logic [31:0] addr);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
    #1 compareNext(PRDATA);
  endtask

  // Write, then confirm pads still show the old value half a cycle later and the new one a cycle later.
  task automatic writeCheckPads(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                                input logic [31:0] oldO, input logic [31:0] newO,
                                input logic [31:0] oldOe, input logic [31:0] newOe);
    apbWrite(addr, data, strb);
    expectValue($sformatf("gpio_o_hold_a%0d", addr), oldO);
    expectValue($sformatf("gpio_oe_hold_a%0d", addr), oldOe);
    expectValue($sformatf("gpio_o_new_a%0d", addr), newO);
    expectValue($sformatf("gpio_oe_new_a%0d", addr), newOe);
    #1;
    compareNext(gpio_o);
    compareNext(gpio_oe);
    @(negedge PCLK);
    #1;
    compareNext(gpio_o);
    compareNext(gpio_oe);
  endtask

  // Observe TR_STAT and irq_o for a few cycles after an edge on gpio_i[2].
  task automatic edgeTrigger(input logic [PDATA_SIZE-1:0] pins, input string name);
    applyStimulus(pins);
    for (int k = 0; k <= 6; k++) begin
      expectValue($sformatf("%s_trstat_k%0d", name, k), (k >= INPUT_STAGES + 2) ? 32'h4 : 32'h0);
      expectValue($sformatf("%s_irq_k%0d", name, k), (k >= INPUT_STAGES + 3) ? 32'h1 : 32'h0);
    end
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) @(negedge PCLK);
      peekReg(7);
      compareNext({31'b0, irq_o});
    end
    busIdle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    PRESET = 1'b1;
    gpio_i = '1;
    PADDR  = '0; PWDATA = '0; PSTRB = '0;
    busIdle();

    // Reset state, then the synchroniser and filter latency out of reset.
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    expectValue("rst_prdata", 32'h0);
    expectValue("rst_pslverr", 32'h0);
    expectValue("rst_irq", 32'h0);
    expectValue("rst_gpio_o", 32'h0);
    expectValue("rst_gpio_oe", 32'h0);
    #1;
    compareNext(PRDATA);
    compareNext({31'b0, PSLVERR});
    compareNext({31'b0, irq_o});
    compareNext(gpio_o);
    compareNext(gpio_oe);
    PRESET = 1'b0;
    for (int k = 0; k <= 3; k++) begin
      expectValue($sformatf("raw_after_rst_k%0d", k), (k >= INPUT_STAGES) ? 32'hFFFF_FFFF : 32'h0);
      expectValue($sformatf("in_after_rst_k%0d", k), (k >= INPUT_STAGES + 1) ? 32'hFFFF_FFFF : 32'h0);
    end
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) @(negedge PCLK);
      peekReg(14);
      peekReg(3);
    end
    busIdle();
    applyStimulus('0);
    for (int a = 0; a <= 13; a++) begin
      if (a != 3) apbRead(a, 32'h0, $sformatf("rst_reg%0d", a));
    end

    // Atomic output aliases with byte strobes; pads follow one cycle later.
    writeCheckPads(1, 32'h0000_FFFF, 4'hF, 32'h0, 32'h0, 32'h0, 32'hFFFF);
    writeCheckPads(2, 32'h0000_00A5, 4'hF, 32'h0, 32'hA5, 32'hFFFF, 32'hFFFF);
    writeCheckPads(9, 32'h0000_0F00, 4'hF, 32'hA5, 32'h0FA5, 32'hFFFF, 32'hFFFF);
    apbRead(2, 32'h0FA5, "out_after_set");
    apbRead(9, 32'h0, "outset_reads0");
    writeCheckPads(11, 32'h0000_00FF, 4'hF, 32'h0FA5, 32'h0F5A, 32'hFFFF, 32'hFFFF);
    apbRead(2, 32'h0F5A, "out_after_tgl");
    writeCheckPads(10, 32'h0000_FFFF, 4'b0010, 32'h0F5A, 32'h005A, 32'hFFFF, 32'hFFFF);
    apbRead(2, 32'h005A, "out_after_clr_strb");
    apbRead(10, 32'h0, "outclr_reads0");

    // Open-drain pin 1: driving 1 releases the pad, driving 0 enables it low.
    writeCheckPads(0, 32'h2, 4'hF, 32'h5A, 32'h58, 32'hFFFF, 32'hFFFD);
    writeCheckPads(10, 32'h2, 4'hF, 32'h58, 32'h58, 32'hFFFD, 32'hFFFF);
    writeCheckPads(3, 32'h5A, 4'hF, 32'h58, 32'h58, 32'hFFFF, 32'hFFFD);
    apbRead(2, 32'h5A, "out_via_input_alias");

    // Debounce on pin 0: a pulse of DBNC_LIMIT samples is dropped, a held level is accepted.
    apbWrite(12, 32'h1, 4'hF);
    apbWrite(13, 32'h0000_0103, 4'hF);
    apbRead(13, DBNC_LIMIT, "dbnc_limit_readback");
    applyStimulus(32'h1);
    for (int k = 0; k <= 9; k++) begin
      expectValue($sformatf("pulse_raw_k%0d", k),
                  (k >= INPUT_STAGES && k < INPUT_STAGES + DBNC_LIMIT) ? 32'h1 : 32'h0);
      expectValue($sformatf("pulse_in_k%0d", k), 32'h0);
    end
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) @(negedge PCLK);
      if (k == DBNC_LIMIT) gpio_i = '0;
      peekReg(14);
      peekReg(3);
    end
    busIdle();
    applyStimulus(32'h1);
    for (int k = 0; k <= 7; k++) begin
      expectValue($sformatf("hold_in_k%0d", k),
                  (k >= INPUT_STAGES + DBNC_LIMIT + 1) ? 32'h1 : 32'h0);
    end
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) @(negedge PCLK);
      peekReg(3);
    end
    busIdle();

    // Any-edge trigger on pin 2, W1C, and a clear colliding with a new edge.
    apbWrite(4, 32'h4, 4'hF);
    apbWrite(5, 32'h4, 4'hF);
    apbWrite(6, 32'h4, 4'hF);
    apbWrite(7, 32'hFFFF_FFFF, 4'hF);
    apbRead(7, 32'h0, "trstat_cleared");
    apbWrite(8, 32'h4, 4'hF);
    edgeTrigger(32'h5, "rise");
    apbWrite(7, 32'h4, 4'hF);
    expectValue("w1c_trstat", 32'h0);
    expectValue("w1c_irq_lag", 32'h1);
    expectValue("w1c_irq_drop", 32'h0);
    peekReg(7);
    compareNext({31'b0, irq_o});
    @(negedge PCLK);
    #1 compareNext({31'b0, irq_o});
    busIdle();
    edgeTrigger(32'h1, "fall");
    apbWrite(7, 32'h4, 4'hF);
    apbRead(7, 32'h0, "trstat_cleared2");
    applyStimulus(32'h5);
    @(negedge PCLK);
    apbWrite(7, 32'h4, 4'hF);
    apbRead(7, 32'h4, "event_beats_clear");

    // Unmapped write is rejected and leaves every register alone.
    apbWrite(32'h20, 32'hDEAD, 4'hF);
    apbRead(32'h20, 32'h0, "unmapped_read");
    apbRead(0, 32'h2, "mode_untouched");
    apbRead(1, 32'hFFFF, "dir_untouched");
    apbRead(2, 32'h5A, "out_untouched");
`ifdef GPIO_LOCK_EN
    apbWrite(15, 32'h1, 4'hF);
    apbRead(15, 32'h1, "lock_readback");
    apbWrite(0, 32'h3, 4'hF);
    apbRead(0, 32'h2, "mode_locked_bit0");
    apbWrite(1, 32'h0, 4'hF);
    apbRead(1, 32'h1, "dir_locked_bit0");
`else
    apbRead(15, 32'h0, "addr15_unmapped");
`endif

    checkOutput("sb_drained", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
